// File: rtl/addsub_pkg.sv
// Shared types and constant helpers for the pipelined add/subtract unit.
package addsub_pkg;

  // Per-transaction mode bits that travel down the pipeline with the operands.
  typedef struct packed {
    logic sub;
    logic sat;
  } op_t;

  function automatic int calc_nseg(input int n, input int seg);
    return n / seg;
  endfunction

  function automatic logic [63:0] signed_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/pipelined_addsub_seg_add_stage.sv
// One pipeline stage: ripple-adds segment IDX and forwards operands, partial sum and mode bits.
module seg_add_stage
  import addsub_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4,
  parameter int IDX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         prev_valid,
  input  logic [N-1:0] prev_a,
  input  logic [N-1:0] prev_b,
  input  logic [N-1:0] prev_sum,
  input  logic         prev_carry,
  input  op_t          prev_op,
  output logic         valid,
  output logic [N-1:0] a_hold,
  output logic [N-1:0] b_hold,
  output logic [N-1:0] sum,
  output logic         carry,
  output op_t          op
);

  localparam int LO = IDX * SEG;

  logic [SEG-1:0] seg_sum;
  logic [SEG:0]   c;
  logic [N-1:0]   next_sum;

  always_comb begin
    // NOTE: blocking assignments here, so each bit sees the carry produced by the bit below it.
    c        = '0;
    seg_sum  = '0;
    c[0]     = prev_carry;
    for (int i = 0; i < SEG; i++) begin
      seg_sum[i] = prev_a[LO+i] ^ prev_b[LO+i] ^ c[i];
      c[i+1]     = (prev_a[LO+i] & prev_b[LO+i]) | (c[i] & (prev_a[LO+i] ^ prev_b[LO+i]));
    end
    next_sum            = prev_sum;
    next_sum[LO +: SEG] = seg_sum;
  end

  // NOTE: data registers are reset as well, so a freshly reset unit presents sum = 0, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
      sum    <= '0;
      carry  <= 1'b0;
      op     <= '0;
    end else if (advance) begin
      // NOTE: non-blocking updates, so every stage samples its neighbour's pre-edge value.
      valid  <= prev_valid;
      a_hold <= prev_a;
      b_hold <= prev_b;
      sum    <= next_sum;
      carry  <= c[SEG];
      op     <= prev_op;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/subtract with valid/ready flow control, signed saturation and result flags.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op_sub,
  input  logic         op_sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int          NSEG   = calc_nseg(N, SEG);
  localparam logic [63:0] SMAX_W = signed_max(N);
  localparam logic [63:0] SMIN_W = signed_min(N);
  localparam logic [N-1:0] SMAX  = SMAX_W[N-1:0];
  localparam logic [N-1:0] SMIN  = SMIN_W[N-1:0];

  if (N % SEG != 0) begin : g_bad_seg
    $error("pipelined_addsub: N must be a multiple of SEG");
  end
  if (N > 64) begin : g_bad_width
    $error("pipelined_addsub: N above 64 is not supported");
  end

  logic                  advance;
  logic [NSEG:0]         v_p;
  logic [NSEG:0]         c_p;
  logic [NSEG:0][N-1:0]  a_p;
  logic [NSEG:0][N-1:0]  b_p;
  logic [NSEG:0][N-1:0]  s_p;
  op_t  [NSEG:0]         op_p;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + ~borrow, so stage inputs are pre-inverted here.
  assign v_p[0]  = in_valid;
  assign a_p[0]  = a;
  assign b_p[0]  = op_sub ? ~b : b;
  assign c_p[0]  = op_sub ? ~cin : cin;
  assign s_p[0]  = '0;
  assign op_p[0] = '{sub: op_sub, sat: op_sat};

  for (genvar s = 0; s < NSEG; s++) begin : g_stage
    seg_add_stage #(
      .N   (N),
      .SEG (SEG),
      .IDX (s)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (advance),
      .prev_valid (v_p[s]),
      .prev_a     (a_p[s]),
      .prev_b     (b_p[s]),
      .prev_sum   (s_p[s]),
      .prev_carry (c_p[s]),
      .prev_op    (op_p[s]),
      .valid      (v_p[s+1]),
      .a_hold     (a_p[s+1]),
      .b_hold     (b_p[s+1]),
      .sum        (s_p[s+1]),
      .carry      (c_p[s+1]),
      .op         (op_p[s+1])
    );
  end

  logic [N-1:0] raw;
  logic         carry_msb;
  logic         a_msb;
  logic         b_msb;
  logic         ovf_raw;
  op_t          fop;

  assign raw       = s_p[NSEG];
  assign carry_msb = c_p[NSEG];
  assign a_msb     = a_p[NSEG][N-1];
  assign b_msb     = b_p[NSEG][N-1];
  assign fop       = op_p[NSEG];
  assign out_valid = v_p[NSEG];

  assign ovf_raw = (a_msb == b_msb) & (raw[N-1] != a_msb);

  always_comb begin
    sum = raw;
    if (fop.sat && ovf_raw) begin
      sum = a_msb ? SMIN : SMAX;
    end
  end

  // Flags are qualified by out_valid so an idle or reset unit reports all zeros.
  assign cout = out_valid & (fop.sub ? ~carry_msb : carry_msb);
  assign ovf  = out_valid & ovf_raw;
  assign zero = out_valid & (sum == '0);

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined successor to the team's ripple add/subtract unit, for the MACC datapath.
- Splits an N-bit add/subtract into NSEG = N/SEG ripple segments, one segment per pipeline stage, with operand skew and result deskew registers.
- Adds valid/ready flow control and per-transaction ops: add, subtract, carry/borrow-in and signed saturation.
- Reports carry/borrow, signed overflow and zero flags, aligned with the result.

Parameters:
N, 16, operand/result width in bits; N % SEG must be 0 (elaboration error otherwise)
SEG, 4, bits resolved per pipeline stage; SEG == N gives a single-stage adder

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  unit accepts a transaction this cycle
a  in  N  operand A (two's complement when saturating)
b  in  N  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
op_sub  in  1  0 = A+B+cin, 1 = A-B-cin
op_sat  in  1  1 = clamp signed overflow to the signed max/min
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
sum  out  N  result
cout  out  1  add: carry out of the MSB; sub: borrow (1 when A < B+cin unsigned)
ovf  out  1  signed overflow of the unclamped result
zero  out  1  final sum == 0 (after any clamping)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valid bits 0, so out_valid = 0; sum = 0; cout = ovf = zero = 0; in_ready = 1.
- Reset mid-operation discards all in-flight transactions. No partial result is emitted after rst_n rises.
- Pipeline advance: advance = ~out_valid | out_ready. The pipeline moves globally; there is no bubble collapsing.
  - in_ready = advance, purely combinational from out_valid and out_ready.
  - A transaction is accepted when in_valid & in_ready.
- Latency: a transaction accepted at edge k gives out_valid at edge k+NSEG, if no stall occurs.
  - Throughput is 1 per cycle.
  - While out_valid & ~out_ready, all stage registers and outputs hold stable.
- Stage 0, at acceptance:
  - b_eff = op_sub ? ~b : b.
  - c0 = op_sub ? ~cin : cin.
  - Registers segment 0 of a + b_eff + c0, its carry, the unresolved upper operand bits, op_sat, and the two operand MSBs.
- Stage s (1..NSEG-1): ripple-adds segment s using the carry registered by stage s-1. Completed lower segments pass through deskew registers.
- Final stage:
  - raw = assembled N-bit sum; c = carry out of the MSB.
  - cout = op_sub ? ~c : c.
  - ovf = (aMSB == b_effMSB) & (rawMSB != aMSB).
  - If op_sat & ovf: sum = aMSB ? 100..0 : 011..1. Otherwise sum = raw.
  - zero computed on the final sum.
- Unsigned wrap-around: results wrap modulo 2^N; cout flags it.
- Simultaneous events:
  - Acceptance and output drain in the same cycle are allowed when out_ready = 1.
  - in_valid while stalled is ignored; the source must hold its data, as in_ready = 0.
- Without a transaction, stage valid bits shift 0 and data registers may hold any value. Only out_valid qualifies the outputs.
- Per-transaction modes travel with their data. Mixed op_sub/op_sat in back-to-back cycles are independent.

Decomposition:
- Package addsub_pkg holds:
  - the NSEG computation as a constant function;
  - signed max/min constant functions of N;
  - the op bundle typedef {op_sub, op_sat}, if the codebase's language level allows.
- Sub-module seg_add_stage (parameter SEG) holds one stage:
  - SEG-bit ripple of full adders plus carry register;
  - valid/advance enable;
  - pass-through of the remaining operand and result slices.
- The top instantiates NSEG of these in a generate loop, plus the final flag and saturation logic.

Test Plan:
- N=16, SEG=4, out_ready=1: a=0x1234, b=0x0FF1, cin=0, add -> after 4 cycles sum=0x2225, cout=0, ovf=0, zero=0.
- Sub: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=1 (borrow), ovf=0. Then a=b=0x8000 -> sum=0x0000, zero=1, cout=0.
- Saturation, each sent with op_sat=1 and repeated with op_sat=0:
  - a=0x7FFF, b=0x0001, add -> sum=0x7FFF, ovf=1 (op_sat=0: sum=0x8000, ovf=1).
  - a=0x8000, b=0x0001, sub -> sum=0x8000, ovf=1.
- Carry chain across all segments: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1.
  - Repeat with SEG=16 and SEG=1: same results, latency 1 and 16 respectively.
- Back-pressure:
  - Stream 8 random transactions with out_ready toggled 1,0,0,1,...
  - Expect in-order results matching a reference model, no drops or duplicates.
  - Outputs stay stable while stalled; in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> out_valid=0 and sum=0 immediately (asynchronous).
  - After release, a new a=1, b=1 add yields only sum=2, 4 cycles later.
